// File: rtl/cronometro_pkg.sv
// Shared constants for the BCD stopwatch: FSM state encodings and decade-digit helpers.
package cronometro_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ZERADO   = 2'b00;
  localparam logic [1:0] CONTANDO = 2'b01;
  localparam logic [1:0] PAUSADO  = 2'b10;
  localparam logic [1:0] PARADO   = 2'b11;

  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/cronometro_bcd_digit.sv
// One decade counter 0..9; clr beats inc, and carry flags a 9 -> 0 roll.
module bcd_digit
  import cronometro_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc)
      q <= bcd_inc(q);
  end

  assign carry = inc & (q == BCD_MAX);

endmodule

// File: rtl/cronometro_param.sv
// Parametrised BCD stopwatch: prescaled N-digit decade counter under a 4-state command FSM.
// Optional lap capture register (volta/digitos_v) is enabled by defining CRONO_LAP_EN.
module cronometro_param
  import cronometro_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int N_DIGITS = 4,
  parameter int WRAP     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          contar,
  input  logic                          pausar,
  input  logic                          parar,
  input  logic                          zerar,
`ifdef CRONO_LAP_EN
  input  logic                          volta,
  output logic [DIGIT_W*N_DIGITS-1:0]   digitos_v,
`endif
  output logic [DIGIT_W*N_DIGITS-1:0]   digitos,
  output logic [1:0]                    estado,
  output logic                          estouro
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [1:0]          state, state_nxt;
  logic [PW-1:0]       presc;
  logic                run, tick, full, ovf, inc0;
  logic [N_DIGITS-1:0] inc, carry, is9;

  // Digit chain: each digit advances on the carry of the one below it.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign inc[i] = inc0;
    end else begin : g_upper
      assign inc[i] = carry[i-1];
    end

    bcd_digit u_dig (
      .clk   (clock),
      .rst_n (reset),
      .clr   (zerar),
      .inc   (inc[i]),
      .q     (digitos[DIGIT_W*i +: DIGIT_W]),
      .carry (carry[i])
    );

    assign is9[i] = (digitos[DIGIT_W*i +: DIGIT_W] == BCD_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= ZERADO;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (zerar) begin
      state_nxt = ZERADO;
    end else begin
      case (state)
        ZERADO:   if (contar) state_nxt = CONTANDO;
        CONTANDO: begin
          if ((WRAP == 0) && ovf) state_nxt = PARADO;
          else if (parar)         state_nxt = PARADO;
          else if (pausar)        state_nxt = PAUSADO;
        end
        PAUSADO: begin
          if (parar)       state_nxt = PARADO;
          else if (contar) state_nxt = CONTANDO;
        end
        default:  state_nxt = PARADO;
      endcase
    end
  end

  // In saturate mode the full-scale tick is swallowed so the 9s hold.
  always_comb begin
    run  = (state == CONTANDO);
    tick = run && (presc == PMAX);
    full = &is9;
    ovf  = (WRAP != 0) ? carry[N_DIGITS-1] : (tick && full);
    inc0 = tick && !((WRAP == 0) && full);
  end

  assign estado = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      presc <= '0;
    else if (zerar)
      presc <= '0;
    else if (run)
      presc <= tick ? '0 : presc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      estouro <= 1'b0;
    else if (zerar)
      estouro <= 1'b0;
    else if (WRAP != 0)
      estouro <= ovf;
    else if (ovf)
      estouro <= 1'b1;
  end

`ifdef CRONO_LAP_EN
  logic [DIGIT_W*N_DIGITS-1:0] digitos_nxt;

  // Lap captures the value the digits take at this same edge.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lap
    assign digitos_nxt[DIGIT_W*i +: DIGIT_W] =
      inc[i] ? bcd_inc(digitos[DIGIT_W*i +: DIGIT_W]) : digitos[DIGIT_W*i +: DIGIT_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      digitos_v <= '0;
    else if (zerar)
      digitos_v <= '0;
    else if (run && volta)
      digitos_v <= digitos_nxt;
  end
`endif

endmodule

// File: tb/tb_cronometro_param.sv
// Directed bench: a wrapping and a saturating stopwatch share one command stream.
module tb_cronometro_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       contar = 1'b0, pausar = 1'b0, parar = 1'b0, zerar = 1'b0;
  logic [7:0] dig_w, dig_s;
  logic [1:0] est_w, est_s;
  logic       ovf_w, ovf_s;
`ifdef CRONO_LAP_EN
  logic       volta = 1'b0;
  logic [7:0] lap_w, lap_s;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cronometro_param #(.CLK_DIV(4), .N_DIGITS(2), .WRAP(1)) u_wrap (
    .clock(clock), .reset(reset), .contar(contar), .pausar(pausar),
    .parar(parar), .zerar(zerar),
`ifdef CRONO_LAP_EN
    .volta(volta), .digitos_v(lap_w),
`endif
    .digitos(dig_w), .estado(est_w), .estouro(ovf_w)
  );

  cronometro_param #(.CLK_DIV(4), .N_DIGITS(2), .WRAP(0)) u_sat (
    .clock(clock), .reset(reset), .contar(contar), .pausar(pausar),
    .parar(parar), .zerar(zerar),
`ifdef CRONO_LAP_EN
    .volta(volta), .digitos_v(lap_s),
`endif
    .digitos(dig_s), .estado(est_s), .estouro(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmd(input logic c, input logic pa, input logic st, input logic z);
    contar = c; pausar = pa; parar = st; zerar = z;
    cyc(1);
    contar = 1'b0; pausar = 1'b0; parar = 1'b0; zerar = 1'b0;
  endtask

  initial begin
    // Reset held, then released just after an edge
    cyc(3);
    chk("rst_dig", dig_w, 8'h00);
    chk("rst_est", est_w, 2'b00);
    chk("rst_ovf", ovf_w, 1'b0);
    reset = 1'b1;
    cyc(1);

    // Count 40 cycles: 10 ticks
    cmd(1, 0, 0, 0);
    chk("start_est", est_w, 2'b01);
    cyc(40);
    chk("run40_dig", dig_w, 8'h10);
    chk("run40_est", est_w, 2'b01);

    // Pause on the 6th CONTANDO edge: prescaler held at 2
    cmd(0, 0, 0, 1);
    chk("zerar_dig", dig_w, 8'h00);
    cmd(1, 0, 0, 0);
    cyc(5);
    cmd(0, 1, 0, 0);
    chk("pause_est", est_w, 2'b10);
    chk("pause_dig", dig_w, 8'h01);
    cyc(20);
    chk("pause_hold", dig_w, 8'h01);
    cmd(1, 0, 0, 0);
    chk("resume_est", est_w, 2'b01);
    cyc(1);
    chk("resume_p3", dig_w, 8'h01);
    cyc(1);
    chk("resume_tick", dig_w, 8'h02);

    // Full scale on both builds
    cmd(0, 0, 0, 1);
    cmd(1, 0, 0, 0);
    cyc(396);
    chk("full_w", dig_w, 8'h99);
    chk("full_s", dig_s, 8'h99);
    chk("full_ovf_w", ovf_w, 1'b0);
    cyc(3);
    chk("prewrap_w", dig_w, 8'h99);
    cyc(1);
    chk("wrap_dig", dig_w, 8'h00);
    chk("wrap_ovf", ovf_w, 1'b1);
    chk("wrap_est", est_w, 2'b01);
    chk("sat_dig", dig_s, 8'h99);
    chk("sat_ovf", ovf_s, 1'b1);
    chk("sat_est", est_s, 2'b11);
    cyc(1);
    chk("wrap_ovf_pulse", ovf_w, 1'b0);
    chk("sat_ovf_hold", ovf_s, 1'b1);
    cyc(3);
    chk("wrap_continues", dig_w, 8'h01);
    chk("sat_frozen", dig_s, 8'h99);

    // Priority: zerar wins over parar and contar
    cmd(1, 0, 1, 1);
    chk("prio_est", est_w, 2'b00);
    chk("prio_dig", dig_w, 8'h00);
    chk("prio_ovf_s", ovf_s, 1'b0);
    cmd(1, 0, 0, 0);
    cyc(2);
    cmd(0, 1, 0, 0);
    chk("p2_est", est_w, 2'b10);
    cmd(0, 0, 1, 0);
    chk("stop_est", est_w, 2'b11);
    cmd(1, 0, 0, 0);
    chk("stop_ign_est", est_w, 2'b11);
    chk("stop_ign_dig", dig_w, 8'h00);
    cmd(0, 0, 0, 1);
    chk("stop_zerar", est_w, 2'b00);

`ifdef CRONO_LAP_EN
    cmd(1, 0, 0, 0);
    cyc(148);
    chk("lap_pre", dig_w, 8'h37);
    volta = 1'b1;
    cyc(1);
    volta = 1'b0;
    chk("lap_cap", lap_w, 8'h37);
    chk("lap_est", est_w, 2'b01);
    cyc(3);
    chk("lap_count", dig_w, 8'h38);
    chk("lap_hold", lap_w, 8'h37);
    cmd(0, 0, 0, 1);
    chk("lap_clr", lap_w, 8'h00);
`endif

    // Asynchronous reset mid-cycle
    cmd(0, 0, 0, 1);
    cmd(1, 0, 0, 0);
    cyc(9);
    chk("arst_pre", dig_w, 8'h02);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_dig", dig_w, 8'h00);
    chk("arst_est", est_w, 2'b00);
    chk("arst_ovf", ovf_w, 1'b0);
    cyc(1);
    reset = 1'b1;
    cyc(4);
    chk("arst_stays", est_w, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
